// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: optional boot-time program load over a valid/ready
// stream, then sequential fetch with decode stall, branch redirect and end-of-memory halt.
module fetch_ctrl #(
  parameter int                    ADDR_W    = 8,
  parameter int                    INSTR_W   = 16,
  parameter int                    MEM_DEPTH = 64,
  parameter logic [INSTR_W-1:0]    NOP_WORD  = 16'h04A0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boot_mode,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic [ADDR_W-1:0]  mem_adr,
  output logic               mem_wr_en,
  output logic [INSTR_W-1:0] mem_wr_data,
  input  logic [INSTR_W-1:0] mem_rd_data,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ld_ptr;

  logic ld_accept;
  logic ld_done;
  logic br_in_range;
  logic at_last;

  assign ld_accept   = ld_valid & ld_ready;
  assign ld_done     = ld_accept & (ld_last | (ld_ptr == LAST_ADR));
  assign br_in_range = (br_target <= LAST_ADR);
  assign at_last     = (pc == LAST_ADR);

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = boot_mode ? LOAD : RUN;
      LOAD: if (ld_done) state_next = RUN;
      RUN: begin
        if (br_taken) begin
          state_next = br_in_range ? RUN : HALT;
        end else if (!stall && at_last) begin
          state_next = HALT;
        end
      end
      HALT: if (br_taken && br_in_range) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // The load handshake is gated by reset so a host cannot push a word while the
  // sequencer is being pulled back to IDLE.
  always_comb begin
    ld_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = ld_data;
    mem_adr     = pc;
    if (state == LOAD) begin
      ld_ready  = ~reset;
      mem_adr   = ld_ptr;
      mem_wr_en = ld_valid & ~reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      ld_ptr   <= '0;
      if_instr <= NOP_WORD;
      if_pc    <= '0;
      if_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      halted <= (state_next == HALT);
      case (state)
        IDLE: begin
          pc     <= '0;
          ld_ptr <= '0;
        end
        LOAD: begin
          if_valid <= 1'b0;
          if (ld_accept) ld_ptr <= ld_ptr + 1'b1;
          if (ld_done)   pc     <= '0;
        end
        RUN: begin
          if (br_taken) begin
            if_instr <= NOP_WORD;
            if_valid <= 1'b0;
            pc       <= br_target;
          end else if (!stall) begin
            if_instr <= mem_rd_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            if (!at_last) pc <= pc + 1'b1;
          end
        end
        HALT: begin
          // The final fetched word is delivered once, then the slot drains to a bubble.
          if (br_taken) begin
            if_instr <= NOP_WORD;
            if_valid <= 1'b0;
            if (br_in_range) pc <= br_target;
          end else if (!stall) begin
            if_instr <= NOP_WORD;
            if_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: behavioural instruction memory, a small fetch model
// feeding a scoreboard queue, and immediate-assertion checks.
module tb_fetch_ctrl;

  localparam logic [15:0] NOP = 16'h04A0;

  logic        clk;
  logic        reset;
  logic        boot_mode;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  mem_adr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        stall;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .boot_mode   (boot_mode),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .mem_adr     (mem_adr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read.
  logic [15:0] mem    [64];
  logic [15:0] golden [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 16'h1000 + 16'(i);
      golden[i] = 16'h1000 + 16'(i);
    end
  end

  always @(posedge clk) begin
    if (mem_wr_en && mem_adr < 8'd64) mem[mem_adr[5:0]] <= mem_wr_data;
  end

  assign mem_rd_data = (mem_adr < 8'd64) ? mem[mem_adr[5:0]] : 16'hDEAD;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        halt;
    logic [7:0]  adr;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_pc;
  logic [7:0]  m_ifpc;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc    = 8'd0;
    m_ifpc  = 8'd0;
    m_instr = NOP;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  // One RUN/HALT cycle: predict, push, clock, pop and compare.
  task automatic cyc(input logic st, input logic br, input logic [7:0] tgt);
    exp_t e;
    stall     = st;
    br_taken  = br;
    br_target = tgt;
    if (br) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (tgt < 8'd64 || !m_halt) m_pc = tgt;
      m_halt  = (tgt >= 8'd64);
    end else if (!st) begin
      if (m_halt) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else begin
        m_valid = 1'b1;
        m_instr = golden[m_pc[5:0]];
        m_ifpc  = m_pc;
        if (m_pc == 8'd63) m_halt = 1'b1;
        else m_pc = m_pc + 8'd1;
      end
    end
    e.valid = m_valid;
    e.instr = m_instr;
    e.pc    = m_ifpc;
    e.halt  = m_halt;
    e.adr   = m_pc;
    sb.push_back(e);
    step();
    stall    = 1'b0;
    br_taken = 1'b0;
    e = sb.pop_front();
    check("if_valid", 32'(if_valid), 32'(e.valid));
    check("if_instr", 32'(if_instr), 32'(e.instr));
    if (e.valid) check("if_pc", 32'(if_pc), 32'(e.pc));
    check("halted", 32'(halted), 32'(e.halt));
    check("mem_adr", 32'(mem_adr), 32'(e.adr));
  endtask

  task automatic load_word(input logic [15:0] d, input logic last, input logic [7:0] adr);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #1;
    check("ld_ready", 32'(ld_ready), 32'd1);
    check("ld_wr_en", 32'(mem_wr_en), 32'd1);
    check("ld_adr", 32'(mem_adr), 32'(adr));
    golden[adr[5:0]] = d;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    boot_mode = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    model_reset();

    // Reset state
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    step();
    step();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", 32'(if_instr), 32'(NOP));
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Boot load of three words
    reset     = 1'b0;
    boot_mode = 1'b1;
    step();
    load_word(16'h9201, 1'b0, 8'd0);
    load_word(16'h9402, 1'b0, 8'd1);
    load_word(16'h9603, 1'b1, 8'd2);
    boot_mode = 1'b0;
    #1;
    check("boot_ld_ready_off", 32'(ld_ready), 32'd0);
    check("boot_wr_en_off", 32'(mem_wr_en), 32'd0);
    check("boot_run_adr", 32'(mem_adr), 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0);

    // Non-boot start, sequential fetch, stall, branch under stall
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("nb_first_valid", 32'(if_valid), 32'd0);
    check("nb_first_adr", 32'(mem_adr), 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd20);
    cyc(1'b0, 1'b0, 8'd0);

    // Run to end of memory, drain, redirect back, then out-of-range redirect
    for (int i = 0; i < 100 && !m_halt; i++) cyc(1'b0, 1'b0, 8'd0);
    check("end_reached", 32'(m_halt), 32'd1);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd70);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'd0);

    // Reset in the middle of a load
    reset = 1'b1;
    step();
    reset     = 1'b0;
    boot_mode = 1'b1;
    step();
    load_word(16'hA001, 1'b0, 8'd0);
    load_word(16'hA002, 1'b0, 8'd1);
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'hA003;
    #1;
    check("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    step();
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    reset    = 1'b0;
    ld_valid = 1'b0;
    step();
    check("kept_word0", 32'(mem[0]), 32'h0000A001);
    check("kept_word1", 32'(mem[1]), 32'h0000A002);
    check("kept_word2", 32'(mem[2]), 32'h00009603);
    load_word(16'hA0FF, 1'b1, 8'd0);
    boot_mode = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
